// File: rtl/vedic_mult_pipe_pkg.sv
// Shared limits, latency helper and stage-valid type for the Vedic multiplier.
// VEDIC_SIGNED_EN adds the sign/magnitude pre-stage, one cycle more latency.
package vedic_pkg;
   localparam int MIN_WIDTH  = 2;
   localparam int MAX_STAGES = 16;

   typedef logic [MAX_STAGES-1:0] stage_vld_t;

   function automatic bit is_pow2(input int width);
      return (width >= MIN_WIDTH) && ((width & (width - 1)) == 0);
   endfunction

   function automatic int vedic_latency(input int width);
`ifdef VEDIC_SIGNED_EN
      return $clog2(width) + 2;
`else
      return $clog2(width) + 1;
`endif
   endfunction
endpackage

// File: rtl/vedic_mult_pipe_if.sv
// Operand/product stream bundle; master drives operands, slave is the multiplier.
interface vedic_mult_pipe_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic               in_valid;
   logic               in_ready;
   logic [2*WIDTH-1:0] result;
   logic               out_valid;
   logic               out_ready;

   modport master (output a, b, in_valid, out_ready, input in_ready, result, out_valid);
   modport slave  (input a, b, in_valid, out_ready, output in_ready, result, out_valid);
endinterface

// File: rtl/vedic_mult_pipe_core.sv
// Registered 2x2 Urdhva cell and the recursive W x W core built from it;
// every recursion level contributes exactly one register stage.
module vedic_cell_2x2_reg (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en_i,
   input  logic [1:0] a_i,
   input  logic [1:0] b_i,
   output logic [3:0] p_o
);
   logic       t11;
   logic       c1;
   logic [3:0] p_d;
   logic [3:0] p_q;

   always_comb begin
      t11 = a_i[1] & b_i[1];
      c1  = (a_i[0] & b_i[1]) & (a_i[1] & b_i[0]);
      p_d = {c1 & t11, c1 ^ t11, (a_i[0] & b_i[1]) ^ (a_i[1] & b_i[0]), a_i[0] & b_i[0]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    p_q <= '0;
      else if (en_i) p_q <= p_d;
   end

   assign p_o = p_q;
endmodule

module vedic_mult_core #(
   parameter int W = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           en_i,
   input  logic [W-1:0]   a_i,
   input  logic [W-1:0]   b_i,
   output logic [2*W-1:0] p_o
);
   if (W == 2) begin : g_leaf
      vedic_cell_2x2_reg u_cell (
         .clk(clk), .rst_n(rst_n), .en_i(en_i), .a_i(a_i), .b_i(b_i), .p_o(p_o)
      );
   end else begin : g_node
      localparam int H = W / 2;
      logic [W-1:0]   ll, lh, hl, hh;
      logic [W:0]     mid;
      logic [2*W-1:0] p_d;
      logic [2*W-1:0] p_q;

      vedic_mult_core #(.W(H)) u_ll (.clk(clk), .rst_n(rst_n), .en_i(en_i),
         .a_i(a_i[H-1:0]), .b_i(b_i[H-1:0]), .p_o(ll));
      vedic_mult_core #(.W(H)) u_lh (.clk(clk), .rst_n(rst_n), .en_i(en_i),
         .a_i(a_i[H-1:0]), .b_i(b_i[W-1:H]), .p_o(lh));
      vedic_mult_core #(.W(H)) u_hl (.clk(clk), .rst_n(rst_n), .en_i(en_i),
         .a_i(a_i[W-1:H]), .b_i(b_i[H-1:0]), .p_o(hl));
      vedic_mult_core #(.W(H)) u_hh (.clk(clk), .rst_n(rst_n), .en_i(en_i),
         .a_i(a_i[W-1:H]), .b_i(b_i[W-1:H]), .p_o(hh));

      // hh and ll never overlap, so they concatenate; only the cross terms need adding
      always_comb begin
         mid = {1'b0, hl} + {1'b0, lh};
         p_d = {hh, ll} + {{(H-1){1'b0}}, mid, {H{1'b0}}};
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)    p_q <= '0;
         else if (en_i) p_q <= p_d;
      end

      assign p_o = p_q;
   end
endmodule

// File: rtl/vedic_mult_pipe.sv
// Pipelined WIDTH x WIDTH Vedic multiplier with valid/ready flow control.
// VEDIC_SIGNED_EN selects two's-complement operation via a sign/magnitude pre-stage.
module vedic_mult_pipe
   import vedic_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input logic              clk,
   input logic              rst_n,
   vedic_mult_pipe_if.slave mul_if
);
   localparam int D = $clog2(WIDTH);
   localparam int L = vedic_latency(WIDTH);
   localparam stage_vld_t LIVE_MASK = stage_vld_t'((64'd1 << L) - 64'd1);
   localparam stage_vld_t OUT_SEL   = stage_vld_t'(64'd1 << (L - 1));

   if (!is_pow2(WIDTH)) begin : g_bad_width
      $error("vedic_mult_pipe: WIDTH must be a power of two >= %0d", MIN_WIDTH);
   end
   if (L > MAX_STAGES) begin : g_too_deep
      $error("vedic_mult_pipe: latency %0d exceeds %0d stages", L, MAX_STAGES);
   end

   logic               adv;
   logic               out_vld;
   stage_vld_t         vld_d, vld_q;
   logic [WIDTH-1:0]   core_a, core_b;
   logic [2*WIDTH-1:0] core_p, res_d, res_q;

   // A single advance enable freezes every stage together, so no skid storage is needed
   assign out_vld = |(vld_q & OUT_SEL);
   assign adv     = ~out_vld | mul_if.out_ready;
   assign vld_d   = adv ? ({vld_q[MAX_STAGES-2:0], mul_if.in_valid} & LIVE_MASK) : vld_q;

`ifdef VEDIC_SIGNED_EN
   logic [WIDTH-1:0] mag_a_d, mag_b_d, mag_a_q, mag_b_q;
   logic [D:0]       sgn_d, sgn_q;

   // the most-negative operand negates to itself, which is the correct unsigned magnitude
   always_comb begin
      mag_a_d = mul_if.a[WIDTH-1] ? -mul_if.a : mul_if.a;
      mag_b_d = mul_if.b[WIDTH-1] ? -mul_if.b : mul_if.b;
      sgn_d   = {sgn_q[D-1:0], mul_if.a[WIDTH-1] ^ mul_if.b[WIDTH-1]};
      res_d   = sgn_q[D] ? -core_p : core_p;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mag_a_q <= '0;
         mag_b_q <= '0;
         sgn_q   <= '0;
      end else if (adv) begin
         mag_a_q <= mag_a_d;
         mag_b_q <= mag_b_d;
         sgn_q   <= sgn_d;
      end
   end

   assign core_a = mag_a_q;
   assign core_b = mag_b_q;
`else
   assign core_a = mul_if.a;
   assign core_b = mul_if.b;
   assign res_d  = core_p;
`endif

   vedic_mult_core #(.W(WIDTH)) u_core (
      .clk(clk), .rst_n(rst_n), .en_i(adv), .a_i(core_a), .b_i(core_b), .p_o(core_p)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         res_q <= '0;
      end else begin
         vld_q <= vld_d;
         if (adv) res_q <= res_d;
      end
   end

   assign mul_if.in_ready  = adv;
   assign mul_if.out_valid = out_vld;
   assign mul_if.result    = res_q;
endmodule

// File: tb/tb_vedic_mult_pipe.sv
// Self-checking bench: WIDTH=32 stream/stall/reset/random, WIDTH=2 sweep, WIDTH=16 vector table.
module tb_vedic_mult_pipe;
`ifdef VEDIC_SIGNED_EN
   localparam int SGN = 1;
`else
   localparam int SGN = 0;
`endif
   localparam int L32 = 6 + SGN;
   localparam int L2  = 2 + SGN;
   localparam int L16 = 5 + SGN;
   localparam int NT  = 6;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   vedic_mult_pipe_if #(.WIDTH(32)) if_a ();
   vedic_mult_pipe_if #(.WIDTH(2))  if_b ();
   vedic_mult_pipe_if #(.WIDTH(16)) if_c ();

   vedic_mult_pipe #(.WIDTH(32)) u_a (.clk(clk), .rst_n(rst_n), .mul_if(if_a));
   vedic_mult_pipe #(.WIDTH(2))  u_b (.clk(clk), .rst_n(rst_n), .mul_if(if_b));
   vedic_mult_pipe #(.WIDTH(16)) u_c (.clk(clk), .rst_n(rst_n), .mul_if(if_c));

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] exp;
   } vec16_t;
   vec16_t tbl16[NT];

   int          n_chk = 0;
   int          n_err = 0;
   logic [63:0] q_a[$];
   logic        hold_a;
   logic [63:0] hold_res_a;
   logic        rnd_rdy = 1'b0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] ref32(input logic [31:0] x, input logic [31:0] y);
`ifdef VEDIC_SIGNED_EN
      return {{32{x[31]}}, x} * {{32{y[31]}}, y};
`else
      return {32'b0, x} * {32'b0, y};
`endif
   endfunction

   function automatic logic [3:0] ref2(input logic [3:0] p);
`ifdef VEDIC_SIGNED_EN
      return {{2{p[3]}}, p[3:2]} * {{2{p[1]}}, p[1:0]};
`else
      return {2'b0, p[3:2]} * {2'b0, p[1:0]};
`endif
   endfunction

   task automatic send_a(input logic [31:0] x, input logic [31:0] y, input logic [63:0] e);
      int n = 0;
      if_a.a = x;
      if_a.b = y;
      if_a.in_valid = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!if_a.in_ready && n < 64);
      if (!if_a.in_ready) check("accept_timeout", 64'(if_a.in_ready), 64'd1);
      else q_a.push_back(e);
      @(posedge clk); #1;
      if_a.in_valid = 1'b0;
   endtask

   task automatic drain_a(input string nm);
      int n = 0;
      while (q_a.size() != 0 && n < 500) begin
         @(posedge clk);
         n++;
      end
      repeat (L32 + 2) @(posedge clk);
      #1;
      check(nm, 64'(q_a.size()), 64'd0);
   endtask

   // Scoreboard plus stall-stability watch on the WIDTH=32 output
   always @(negedge clk) begin
      if (!rst_n) hold_a = 1'b0;
      else begin
         if (hold_a) begin
            check("stall_vld", 64'(if_a.out_valid), 64'd1);
            check("stall_res", if_a.result, hold_res_a);
         end
         if (if_a.out_valid && if_a.out_ready) begin
            if (q_a.size() == 0) check("extra_beat", 64'(q_a.size()), 64'd1);
            else check("res32", if_a.result, q_a.pop_front());
         end
         hold_a     = if_a.out_valid && !if_a.out_ready;
         hold_res_a = if_a.result;
      end
   end

   always begin
      @(posedge clk); #1;
      if (rnd_rdy) if_a.out_ready = ($urandom_range(0, 3) != 0);
   end

   initial begin
      #800_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          n;
      logic [3:0]  pb;
      logic [31:0] x, y;
      logic [63:0] lat_exp;

`ifdef VEDIC_SIGNED_EN
      tbl16[0] = '{16'hFFFD, 16'h0005, 32'hFFFF_FFF1};
      tbl16[1] = '{16'h8000, 16'h8000, 32'h4000_0000};
      tbl16[2] = '{16'hFFFF, 16'hFFFF, 32'h0000_0001};
      tbl16[3] = '{16'h7FFF, 16'h7FFF, 32'h3FFF_0001};
      tbl16[4] = '{16'h8000, 16'h0001, 32'hFFFF_8000};
      tbl16[5] = '{16'h0004, 16'hFFFE, 32'hFFFF_FFF8};
      lat_exp  = 64'd1;
`else
      tbl16[0] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
      tbl16[1] = '{16'h0003, 16'h0005, 32'h0000_000F};
      tbl16[2] = '{16'h0000, 16'h1234, 32'h0000_0000};
      tbl16[3] = '{16'h8000, 16'h8000, 32'h4000_0000};
      tbl16[4] = '{16'h00FF, 16'h0101, 32'h0000_FFFF};
      tbl16[5] = '{16'h1234, 16'h0010, 32'h0001_2340};
      lat_exp  = 64'hFFFF_FFFE_0000_0001;
`endif

      rst_n = 1'b0;
      if_a.a = '0; if_a.b = '0; if_a.in_valid = 1'b0; if_a.out_ready = 1'b1;
      if_b.a = '0; if_b.b = '0; if_b.in_valid = 1'b0; if_b.out_ready = 1'b1;
      if_c.a = '0; if_c.b = '0; if_c.in_valid = 1'b0; if_c.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_rdy32", 64'(if_a.in_ready), 64'd1);
      check("rst_vld32", 64'(if_a.out_valid), 64'd0);
      check("rst_res32", if_a.result, 64'd0);
      check("rst_rdy2", 64'(if_b.in_ready), 64'd1);
      check("rst_vld2", 64'(if_b.out_valid), 64'd0);
      check("rst_res2", 64'(if_b.result), 64'd0);
      check("rst_vld16", 64'(if_c.out_valid), 64'd0);
      check("rst_res16", 64'(if_c.result), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // single all-ones product: exact latency
      check("lat_in_ready", 64'(if_a.in_ready), 64'd1);
      if_a.a = '1; if_a.b = '1; if_a.in_valid = 1'b1;
      q_a.push_back(lat_exp);
      @(posedge clk); #1;
      if_a.in_valid = 1'b0;
      n = 1;
      while (!if_a.out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("lat32", 64'(n), 64'(L32));
      check("lat32_res", if_a.result, lat_exp);
      drain_a("lat_drain");

      // WIDTH=2: all 16 pairs back-to-back
      for (int e = 0; e < 15 + L2; e++) begin
         if (e < 16) begin
            pb = 4'(e);
            if_b.a = pb[3:2];
            if_b.b = pb[1:0];
            if_b.in_valid = 1'b1;
         end else if_b.in_valid = 1'b0;
         @(posedge clk); #1;
         if (e + 1 < L2) check("w2_lead", 64'(if_b.out_valid), 64'd0);
         else begin
            pb = 4'(e + 1 - L2);
            check("w2_vld", 64'(if_b.out_valid), 64'd1);
            check("w2_res", 64'(if_b.result), 64'(ref2(pb)));
         end
      end
      if_b.in_valid = 1'b0;
      @(posedge clk); #1;
      check("w2_tail", 64'(if_b.out_valid), 64'd0);

      // WIDTH=16 vector table streamed back-to-back
      for (int e = 0; e < NT - 1 + L16; e++) begin
         if (e < NT) begin
            if_c.a = tbl16[e].a;
            if_c.b = tbl16[e].b;
            if_c.in_valid = 1'b1;
         end else if_c.in_valid = 1'b0;
         @(posedge clk); #1;
         if (e + 1 < L16) check("w16_lead", 64'(if_c.out_valid), 64'd0);
         else begin
            check("w16_vld", 64'(if_c.out_valid), 64'd1);
            check("w16_res", 64'(if_c.result), 64'(tbl16[e + 1 - L16].exp));
         end
      end
      if_c.in_valid = 1'b0;
      @(posedge clk); #1;
      check("w16_tail", 64'(if_c.out_valid), 64'd0);

      // 10 random pairs with a 4-cycle output stall once the pipe is full
      fork
         begin
            logic [31:0] sx, sy;
            for (int i = 0; i < 10; i++) begin
               sx = $urandom;
               sy = $urandom;
               send_a(sx, sy, ref32(sx, sy));
            end
         end
         begin
            repeat (8) @(posedge clk);
            #1;
            if_a.out_ready = 1'b0;
            repeat (4) begin
               @(negedge clk);
               check("stall_in_ready", 64'(if_a.in_ready), 64'd0);
               check("stall_out_valid", 64'(if_a.out_valid), 64'd1);
            end
            @(posedge clk); #1;
            if_a.out_ready = 1'b1;
         end
      join
      drain_a("stall_drain");

      // reset with three products in flight
      for (int i = 0; i < 3; i++) send_a(32'(i + 1), 32'd5, ref32(32'(i + 1), 32'd5));
      rst_n = 1'b0;
      q_a.delete();
      @(posedge clk); #1;
      check("midrst_vld", 64'(if_a.out_valid), 64'd0);
      rst_n = 1'b1;
      for (int k = 0; k < L32; k++) begin
         @(posedge clk); #1;
         check("post_rst_vld", 64'(if_a.out_valid), 64'd0);
      end
      send_a(32'd7, 32'd6, 64'd42);
      drain_a("rst_drain");

      // random regression with random valid/ready
      rnd_rdy = 1'b1;
      for (int i = 0; i < 10000; i++) begin
         case ($urandom_range(0, 7))
            0:       x = 32'h0;
            1:       x = 32'hFFFF_FFFF;
            2:       x = 32'h8000_0000;
            default: x = $urandom;
         endcase
         case ($urandom_range(0, 7))
            0:       y = 32'h0;
            1:       y = 32'hFFFF_FFFF;
            2:       y = 32'h8000_0000;
            default: y = $urandom;
         endcase
         repeat ($urandom_range(0, 1)) begin
            @(posedge clk); #1;
         end
         send_a(x, y, ref32(x, y));
      end
      rnd_rdy = 1'b0;
      if_a.out_ready = 1'b1;
      drain_a("rnd_drain");

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
